// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA scan driver: the per-axis phase
//   enumeration, default 640x480@60 timing, and the colour substituted
//   for active pixels that the pixel source fails to deliver in time.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } h_phase_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CNT_W = 12;

  // Dim blue, so that underruns are visible on screen but not alarming.
  localparam logic [7:0] UNDERRUN_FILL_R = 8'd0;
  localparam logic [7:0] UNDERRUN_FILL_G = 8'd0;
  localparam logic [7:0] UNDERRUN_FILL_B = 8'd32;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis (horizontal or vertical). Walks the
//   ACTIVE -> FRONT -> SYNC -> BACK phase sequence with a per-phase
//   length counter, and keeps the absolute position 0..TOTAL-1.
// Ports
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear back to position 0 / ACTIVE phase
//   adv       advance one position this clock
//   cnt       absolute position on the axis
//   active    position lies in the visible region
//   sync      position lies in the sync pulse
//   wrap      advancing from TOTAL-1 back to 0 this clock (carry out)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = 640,
  parameter int FP_LEN     = 16,
  parameter int SYNC_LEN   = 96,
  parameter int BP_LEN     = 48,
  parameter logic [CNT_W-1:0] TOTAL = 12'd800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LEN_ACT  = CNT_W'(ACTIVE_LEN);
  localparam logic [CNT_W-1:0] LEN_FP   = CNT_W'(FP_LEN);
  localparam logic [CNT_W-1:0] LEN_SYNC = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] LEN_BP   = CNT_W'(BP_LEN);

  h_phase_t         phase, phase_nxt;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] phase_len;
  logic             phase_last;

  assign wrap   = adv && (cnt == TOTAL - CNT_W'(1));
  assign active = (phase == ACTIVE);
  assign sync   = (phase == SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= ACTIVE;
      phase_cnt <= '0;
      cnt       <= '0;
    end else begin
      phase     <= phase_nxt;
      phase_cnt <= phase_cnt_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    phase_nxt     = phase;
    phase_cnt_nxt = phase_cnt;
    cnt_nxt       = cnt;
    case (phase)
      ACTIVE:  phase_len = LEN_ACT;
      FRONT:   phase_len = LEN_FP;
      SYNC:    phase_len = LEN_SYNC;
      BACK:    phase_len = LEN_BP;
      default: phase_len = LEN_ACT;
    endcase
    phase_last = (phase_cnt == phase_len - CNT_W'(1));

    if (clr) begin
      phase_nxt     = ACTIVE;
      phase_cnt_nxt = '0;
      cnt_nxt       = '0;
    end else if (adv) begin
      cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
      // The phase length counter restarts on every phase change so each
      // phase can be checked against its own length independently.
      if (phase_last) begin
        phase_cnt_nxt = '0;
        case (phase)
          ACTIVE:  phase_nxt = FRONT;
          FRONT:   phase_nxt = SYNC;
          SYNC:    phase_nxt = BACK;
          BACK:    phase_nxt = ACTIVE;
          default: phase_nxt = ACTIVE;
        endcase
      end else begin
        phase_cnt_nxt = phase_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver
//   VGA timing master and pixel consumer. Generates raster timing, issues
//   pixel requests to a zero-latency combinational pixel source and
//   registers the returned colour onto the VGA pins together with
//   hsync/vsync/de, one clock after the request.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   enable              low holds the raster at the origin and blanks pins
//   pixel_x, pixel_y    requested pixel (0 outside the visible region)
//   pixel_valid         request strobe: visible AND pixel tick AND enable
//   rgb_r/g/b           colour returned in the same clock as the request
//   output_valid        qualifies rgb_*; missing data becomes fill colour
//   vga_r/g/b           registered colour to the DAC
//   vga_hsync/vga_vsync registered syncs, level SYNC_POL when asserted
//   vga_de              registered data enable
//   frame_start         one-clock pulse on the tick at h=0, v=0
//   frame_cnt           completed frames, wrapping
// Optional build macro VGA_UNDERRUN_CNT_EN adds
//   underrun_cnt        saturating count of visible ticks without data
//   underrun_flag       sticky underrun indication
//   Both are cleared only by rst.
module vga_scan_driver
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        pixel_valid,
  input  logic [7:0]  rgb_r,
  input  logic [7:0]  rgb_g,
  input  logic [7:0]  rgb_b,
  input  logic        output_valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`ifdef VGA_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt,
  output logic        underrun_flag
`endif
);

  localparam logic [CNT_W-1:0] H_TOTAL = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_TOTAL = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic             SYNC_ON   = SYNC_POL;
  localparam logic             SYNC_IDLE = ~SYNC_POL;

  function automatic logic [23:0] pixel_colour(input logic       act,
                                               input logic       ok,
                                               input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
    if (!act) return 24'h000000;
    if (!ok)  return {UNDERRUN_FILL_R, UNDERRUN_FILL_G, UNDERRUN_FILL_B};
    return {r, g, b};
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             tick_p0;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_active, h_sync, h_wrap;
  logic             v_active, v_sync, v_wrap;
  logic             active_p0;
  logic [23:0]      colour_p0;

  // ---- stage p0: raster counters and combinational request ----
  // Ticks are suppressed while rst is high so no request or frame pulse
  // escapes during reset.
  assign tick_p0 = enable && !rst && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      div_cnt <= '0;
    else if (!enable || tick_p0)  div_cnt <= '0;
    else                          div_cnt <= div_cnt + DIV_W'(1);
  end

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP),
    .TOTAL(H_TOTAL)
  ) u_h (
    .clk(clk), .rst(rst), .clr(!enable), .adv(tick_p0),
    .cnt(h_cnt), .active(h_active), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP),
    .TOTAL(V_TOTAL)
  ) u_v (
    .clk(clk), .rst(rst), .clr(!enable), .adv(h_wrap),
    .cnt(v_cnt), .active(v_active), .sync(v_sync), .wrap(v_wrap)
  );

  assign active_p0   = h_active && v_active;
  assign pixel_valid = active_p0 && tick_p0;
  assign pixel_x     = active_p0 ? 10'(h_cnt) : 10'd0;
  assign pixel_y     = active_p0 ? 9'(v_cnt) : 9'd0;
  assign frame_start = tick_p0 && (h_cnt == '0) && (v_cnt == '0);
  assign colour_p0   = pixel_colour(active_p0, output_valid, rgb_r, rgb_g, rgb_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         frame_cnt <= '0;
    else if (v_wrap) frame_cnt <= frame_cnt + 16'd1;
  end

  // ---- stage p1: registered VGA pins, updated only on pixel ticks ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_de    <= 1'b0;
      vga_hsync <= SYNC_IDLE;
      vga_vsync <= SYNC_IDLE;
    end else if (!enable) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_de    <= 1'b0;
      vga_hsync <= SYNC_IDLE;
      vga_vsync <= SYNC_IDLE;
    end else if (tick_p0) begin
      {vga_r, vga_g, vga_b} <= colour_p0;
      vga_de    <= active_p0;
      vga_hsync <= h_sync ? SYNC_ON : SYNC_IDLE;
      vga_vsync <= v_sync ? SYNC_ON : SYNC_IDLE;
    end
  end

`ifdef VGA_UNDERRUN_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic underrun_p0;
  assign underrun_p0 = pixel_valid && !output_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt  <= '0;
      underrun_flag <= 1'b0;
    end else if (underrun_p0) begin
      underrun_cnt  <= sat_inc16(underrun_cnt);
      underrun_flag <= 1'b1;
    end
  end
`endif

endmodule
